// File: rtl/jk_pkg.sv
// Shared definitions for the JK drive sequencer: command opcodes, command word
// layout and the flip-flop next-state rule used by the Q1 predictor.
package jk_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    // A queued command word is {op, len}: op in the top OP_W bits, len below.
    localparam int OP_W = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } seq_state_t;

    function automatic logic jk_next_q(input logic [1:0] jk, input logic q);
        case (jk)
            OP_RST:  return 1'b0;
            OP_SET:  return 1'b1;
            OP_TGL:  return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with fall-through head, occupancy count and a
// single-cycle flush that empties it.
module jk_cmd_fifo
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == (PTR_W+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/jk_drive_seq.sv
// Command sequencer that replays queued HOLD/RESET/SET/TOGGLE commands on the
// J/K inputs of the downstream flip-flop and predicts its Q1 output.
module jk_drive_seq
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [1:0]               CMD_OP,
    input  logic [CNT_W-1:0]         CMD_LEN,
    input  logic                     FLUSH,
    output logic                     J,
    output logic                     K,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     Q_EXP,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int CMD_W = OP_W + CNT_W;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] head;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       jk;
    logic [1:0]       jk_nxt;
    logic             q_exp;

    // No pop-through: readiness looks only at registered occupancy and FLUSH.
    assign CMD_READY = !fifo_full && !FLUSH;
    assign push      = CMD_VALID && CMD_READY;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .flush (FLUSH),
        .din   ({CMD_OP, CMD_LEN}),
        .dout  (head),
        .level (LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_op  = head[CMD_W-1 -: OP_W];
    assign head_len = head[CNT_W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            jk    <= OP_HOLD;
            q_exp <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            jk    <= jk_nxt;
            // Tracks the flip-flop, which sees the J/K driven this cycle even on a flush.
            q_exp <= jk_next_q(jk, q_exp);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        jk_nxt    = jk;
        pop       = 1'b0;
        if (FLUSH) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            jk_nxt    = OP_HOLD;
        end else if (state == S_RUN && cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end else if (!fifo_empty) begin
            // Covers both IDLE start and back-to-back reload on the last cycle.
            pop       = 1'b1;
            state_nxt = S_RUN;
            cnt_nxt   = head_len;
            jk_nxt    = head_op;
        end else begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            jk_nxt    = OP_HOLD;
        end
    end

    always_comb begin
        BUSY = (state == S_RUN);
        DONE = (state == S_RUN) && (cnt == '0);
    end

    assign J     = jk[1];
    assign K     = jk[0];
    assign Q_EXP = q_exp;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Bench for jk_drive_seq: directed scenarios plus random traffic, checked against
// a command-queue model and a behavioural JK flip-flop on the J/K outputs.
module tb_jk_drive_seq;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RSTC = 2'b01;
    localparam logic [1:0] SETC = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

    typedef struct {
        logic [1:0]       op;
        logic [CNT_W-1:0] len;
    } cmd_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [CNT_W-1:0] CMD_LEN;
    logic             FLUSH;
    logic             J;
    logic             K;
    logic             BUSY;
    logic             DONE;
    logic             Q_EXP;
    logic [LVL_W-1:0] LEVEL;

    logic Q1;
    logic Q2;

    int errors = 0;
    int checks = 0;

    cmd_t       mq[$];
    logic       m_busy;
    logic [1:0] m_jk;
    int         m_rem;
    logic       m_q;

    always #5 CLK = ~CLK;

    jk_drive_seq #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_LEN   (CMD_LEN),
        .FLUSH     (FLUSH),
        .J         (J),
        .K         (K),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .Q_EXP     (Q_EXP),
        .LEVEL     (LEVEL)
    );

    // Downstream JK flip-flop, written from its characteristic equation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q1 <= 1'b0;
            Q2 <= 1'b1;
        end else begin
            Q1 <= (J & ~Q1) | (~K & Q1);
            Q2 <= ~((J & ~Q1) | (~K & Q1));
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_jk   = 2'b00;
        m_rem  = 0;
        m_q    = 1'b0;
    endtask

    // One clock: apply inputs, check everything visible before the edge, advance the model.
    task automatic step(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] len,
                        input logic fl, input logic rs);
        cmd_t c;
        bit   acc;
        CMD_VALID = v;
        CMD_OP    = op;
        CMD_LEN   = len;
        FLUSH     = fl;
        RST       = rs;
        #1;
        chk("ready", 16'(CMD_READY), 16'((mq.size() < DEPTH) && !fl));
        chk("done",  16'(DONE),      16'(m_busy && (m_rem == 1)));
        chk("j",     16'(J),         16'(m_jk[1]));
        chk("k",     16'(K),         16'(m_jk[0]));
        chk("busy",  16'(BUSY),      16'(m_busy));
        chk("level", 16'(LEVEL),     16'(mq.size()));
        chk("q_exp", 16'(Q_EXP),     16'(m_q));
        chk("q1",    16'(Q1),        16'(m_q));
        chk("q2",    16'(Q2),        16'(!m_q));

        acc = v && (mq.size() < DEPTH) && !fl;
        if (rs) begin
            model_reset();
        end else begin
            if (m_jk == RSTC) m_q = 1'b0;
            else if (m_jk == SETC) m_q = 1'b1;
            else if (m_jk == TGL) m_q = !m_q;
            if (fl) begin
                mq.delete();
                m_busy = 1'b0;
                m_jk   = 2'b00;
                m_rem  = 0;
            end else begin
                if (m_busy) begin
                    m_rem--;
                    if (m_rem == 0) m_busy = 1'b0;
                end
                if (!m_busy) begin
                    if (mq.size() > 0) begin
                        c      = mq.pop_front();
                        m_jk   = c.op;
                        m_rem  = int'(c.len) + 1;
                        m_busy = 1'b1;
                    end else begin
                        m_jk = 2'b00;
                    end
                end
                if (acc) begin
                    c.op  = op;
                    c.len = len;
                    mq.push_back(c);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, HOLD, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int pushes;
        int guard;
        logic [1:0] rop;
        logic [CNT_W-1:0] rlen;

        CMD_VALID = 1'b0;
        CMD_OP    = HOLD;
        CMD_LEN   = '0;
        FLUSH     = 1'b0;
        RST       = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        RST = 1'b0;
        #1;
        chk("rst_j",     16'(J),     16'd0);
        chk("rst_k",     16'(K),     16'd0);
        chk("rst_busy",  16'(BUSY),  16'd0);
        chk("rst_done",  16'(DONE),  16'd0);
        chk("rst_qexp",  16'(Q_EXP), 16'd0);
        chk("rst_level", 16'(LEVEL), 16'd0);
        chk("rst_ready", 16'(CMD_READY), 16'd1);

        // Single SET, LEN=2.
        step(1'b1, SETC, 4'd2, 1'b0, 1'b0);
        idle(1);
        chk("t1_jk_after_e1", 16'({J, K}), 16'b10);
        idle(2);
        chk("t1_done_after_e3", 16'(DONE), 16'd1);
        chk("t1_qexp", 16'(Q_EXP), 16'd1);
        idle(1);
        chk("t1_jk_idle", 16'({J, K}), 16'b00);
        chk("t1_busy_idle", 16'(BUSY), 16'd0);
        idle(2);

        // TOGGLE LEN=3 then RESET LEN=0 back-to-back.
        step(1'b1, TGL, 4'd3, 1'b0, 1'b0);
        step(1'b1, RSTC, 4'd0, 1'b0, 1'b0);
        idle(6);
        chk("t2_final_qexp", 16'(Q_EXP), 16'd0);

        // Fill the FIFO behind a long HOLD, then keep offering until 10 pushes land.
        step(1'b1, HOLD, 4'd15, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, TGL, 4'(i), 1'b0, 1'b0);
        #1;
        chk("t3_level_full", 16'(LEVEL), 16'd4);
        chk("t3_ready_full", 16'(CMD_READY), 16'd0);
        pushes = 5;
        guard  = 0;
        while (pushes < 10 && guard < 200) begin
            rop  = 2'($urandom);
            rlen = 4'($urandom_range(0, 2));
            if (mq.size() < DEPTH) pushes++;
            step(1'b1, rop, rlen, 1'b0, 1'b0);
            guard++;
        end
        chk("t3_push_budget", 16'(pushes), 16'd10);
        idle(40);

        // FLUSH mid-TOGGLE with two queued and a push offered.
        step(1'b1, TGL, 4'd9, 1'b0, 1'b0);
        step(1'b1, SETC, 4'd3, 1'b0, 1'b0);
        step(1'b1, RSTC, 4'd3, 1'b0, 1'b0);
        idle(2);
        step(1'b1, SETC, 4'd1, 1'b1, 1'b0);
        chk("t4_level", 16'(LEVEL), 16'd0);
        chk("t4_busy",  16'(BUSY),  16'd0);
        chk("t4_jk",    16'({J, K}), 16'b00);
        chk("t4_done",  16'(DONE),  16'd0);
        idle(3);

        // RST mid-SET with Q_EXP=1 and three queued.
        step(1'b1, SETC, 4'd9, 1'b0, 1'b0);
        step(1'b1, HOLD, 4'd1, 1'b0, 1'b0);
        step(1'b1, TGL,  4'd1, 1'b0, 1'b0);
        step(1'b1, HOLD, 4'd1, 1'b0, 1'b0);
        chk("t5_pre_level", 16'(LEVEL), 16'd3);
        chk("t5_pre_qexp",  16'(Q_EXP), 16'd1);
        step(1'b0, HOLD, '0, 1'b0, 1'b1);
        chk("t5_qexp",  16'(Q_EXP), 16'd0);
        chk("t5_level", 16'(LEVEL), 16'd0);
        chk("t5_busy",  16'(BUSY),  16'd0);
        chk("t5_jk",    16'({J, K}), 16'b00);
        idle(2);

        // Random co-simulation against the flip-flop.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom), 2'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 499) == 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
